// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared definitions for the VGA draw-stage chain (1024x768 visible,
//   1344x806 total). Holds the mode timing constants, bus widths and the
//   timing-bus struct so that every draw stage can pass the bus along
//   uniformly.
//   No ports (package).
package vga_pkg;

  localparam int HOR_TOTAL   = 1344;
  localparam int VER_TOTAL   = 806;
  localparam int HOR_VISIBLE = 1024;
  localparam int VER_VISIBLE = 768;

  localparam int RGB_W   = 12;
  localparam int COUNT_W = 12;

  // Everything the timing generator produces, grouped so a draw stage can
  // delay and forward it as one value.
  typedef struct packed {
    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
  } timing_bus_t;

endpackage

// File: rtl/timing_delay.sv
// timing_delay
//   N-cycle register pipeline for the VGA timing bus, used by draw stages
//   to keep the timing bus aligned with their own rgb latency.
//   Ports:
//     clk_in  pixel clock
//     rst     synchronous, active-high reset (clears every stage to 0)
//     i_bus   timing bus in
//     o_bus   timing bus delayed by N cycles
module timing_delay
  import vga_pkg::*;
#(
  parameter int N = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  timing_bus_t i_bus,
  output timing_bus_t o_bus
);

  timing_bus_t [N-1:0] r_pipe;

  // Shift the bus one stage per pixel clock; reset empties the whole pipe
  // so no stale timing leaks out after a mid-frame reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_bus;
      for (int k = 1; k < N; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign o_bus = r_pipe[N-1];

endmodule

// File: rtl/draw_puck.sv
// draw_puck
//   Pixel-pipeline draw stage: overlays a filled circular puck on the
//   upstream rgb stream and re-emits the timing bus delayed to match the
//   2-cycle rgb latency.
//   Optional build macro: PUCK_OUTLINE_EN draws an OUTLINE_W-wide ring of
//   OUTLINE_COLOR at the puck edge; otherwise the puck is a solid fill.
//   Ports:
//     clk_in, rst                 pixel clock, synchronous active-high reset
//     hcount_in .. vblnk_in       timing bus from the generator
//     rgb_in                      upstream pixel colour
//     xpos, ypos                  requested puck centre (sampled at vblnk rise)
//     hcount_out .. vblnk_out     timing bus delayed 2 cycles
//     rgb_out                     composited pixel
module draw_puck
  import vga_pkg::*;
#(
  parameter int              RADIUS        = 16,
  parameter logic [RGB_W-1:0] PUCK_COLOR   = 12'hF00,
  parameter int              X_INIT        = 512,
  parameter int              Y_INIT        = 384,
  parameter int              OUTLINE_W     = 2,
  parameter logic [RGB_W-1:0] OUTLINE_COLOR = 12'hFFF
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [COUNT_W-1:0] hcount_in,
  input  logic [COUNT_W-1:0] vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [COUNT_W-1:0] xpos,
  input  logic [COUNT_W-1:0] ypos,
  output logic [COUNT_W-1:0] hcount_out,
  output logic [COUNT_W-1:0] vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [RGB_W-1:0]   rgb_out
);

`ifdef PUCK_OUTLINE_EN
  localparam bit OUTLINE_ON = 1'b1;
`else
  localparam bit OUTLINE_ON = 1'b0;
`endif

  localparam logic [26:0] R2     = 27'(RADIUS * RADIUS);
  localparam logic [26:0] INNER2 = 27'((RADIUS - OUTLINE_W) * (RADIUS - OUTLINE_W));

  logic               r_vblnkPrev;
  logic [COUNT_W-1:0] r_xs;
  logic [COUNT_W-1:0] r_ys;
  logic signed [12:0] r_dx;
  logic signed [12:0] r_dy;
  logic               r_blank1;
  logic [RGB_W-1:0]   r_rgb1;
  logic [RGB_W-1:0]   r_rgb2;

  logic signed [26:0] w_dxExt;
  logic signed [26:0] w_dyExt;
  logic [26:0]        w_d2;
  logic [RGB_W-1:0]   w_color;
  logic               w_vblnkRise;

  timing_bus_t w_busIn;
  timing_bus_t w_busOut;

  // The shadow centre only moves at the start of vertical blank, so a
  // position change mid-frame never tears the puck.
  assign w_vblnkRise = vblnk_in & ~r_vblnkPrev;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_vblnkPrev <= 1'b0;
      r_xs        <= COUNT_W'(X_INIT);
      r_ys        <= COUNT_W'(Y_INIT);
    end else begin
      r_vblnkPrev <= vblnk_in;
      if (w_vblnkRise) begin
        r_xs <= xpos;
        r_ys <= ypos;
      end
    end
  end

  // Stage 1: signed offsets from the centre. Zero-extending to 13 bits
  // first keeps pixels left of / above the centre negative instead of
  // wrapping to large positive values.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_dx     <= '0;
      r_dy     <= '0;
      r_blank1 <= 1'b0;
      r_rgb1   <= '0;
    end else begin
      r_dx     <= {1'b0, hcount_in} - {1'b0, r_xs};
      r_dy     <= {1'b0, vcount_in} - {1'b0, r_ys};
      r_blank1 <= hblnk_in | vblnk_in;
      r_rgb1   <= rgb_in;
    end
  end

  // Squares are taken at full width so the distance never truncates.
  assign w_dxExt = {{14{r_dx[12]}}, r_dx};
  assign w_dyExt = {{14{r_dy[12]}}, r_dy};
  assign w_d2    = 27'(w_dxExt * w_dxExt) + 27'(w_dyExt * w_dyExt);

  // Colour select: blanking wins, then the puck (with its optional ring),
  // otherwise the upstream pixel passes through.
  always_comb begin
    w_color = r_rgb1;
    if (r_blank1) begin
      w_color = '0;
    end else if (w_d2 <= R2) begin
      w_color = (OUTLINE_ON && (w_d2 > INNER2)) ? OUTLINE_COLOR : PUCK_COLOR;
    end
  end

  // Stage 2: register the composited colour.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_rgb2 <= '0;
    end else begin
      r_rgb2 <= w_color;
    end
  end

  assign rgb_out = r_rgb2;

  assign w_busIn.hcount = hcount_in;
  assign w_busIn.vcount = vcount_in;
  assign w_busIn.hsync  = hsync_in;
  assign w_busIn.vsync  = vsync_in;
  assign w_busIn.hblnk  = hblnk_in;
  assign w_busIn.vblnk  = vblnk_in;

  timing_delay #(.N(2)) u_timingDelay (
    .clk_in (clk_in),
    .rst    (rst),
    .i_bus  (w_busIn),
    .o_bus  (w_busOut)
  );

  assign hcount_out = w_busOut.hcount;
  assign vcount_out = w_busOut.vcount;
  assign hsync_out  = w_busOut.hsync;
  assign vsync_out  = w_busOut.vsync;
  assign hblnk_out  = w_busOut.hblnk;
  assign vblnk_out  = w_busOut.vblnk;

endmodule

// File: tb/tb_draw_puck.sv
// tb_draw_puck
//   Directed testbench for draw_puck with hand-computed expected colours.
//   Expected values for the ring pixels change when PUCK_OUTLINE_EN is
//   defined, so the bench honours the same macro.
module tb_draw_puck;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic [11:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int checkCount = 0;
  int errorCount = 0;

  localparam logic [11:0] RED  = 12'hF00;
  localparam logic [11:0] BLUE = 12'h00F;
`ifdef PUCK_OUTLINE_EN
  localparam logic [11:0] RING = 12'hFFF;
`else
  localparam logic [11:0] RING = 12'hF00;
`endif

  draw_puck dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  // 65 MHz-ish pixel clock; exact period is irrelevant to the checks.
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] h, input logic [11:0] v,
                               input logic hs, input logic vs,
                               input logic hb, input logic vb,
                               input logic [11:0] rgb);
    hcount_in = h;
    vcount_in = v;
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
  endtask

  // Push one pixel in, follow it with a neutral filler pixel, and check the
  // colour and delayed hcount/vcount two edges later.
  task automatic probePixel(input string tag, input logic [11:0] h,
                            input logic [11:0] v, input logic hb,
                            input logic [11:0] rgb, input logic [11:0] expRgb);
    applyStimulus(h, v, 1'b0, 1'b0, hb, 1'b0, rgb);
    @(posedge clk_in); #1;
    applyStimulus(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    @(posedge clk_in); #1;
    checkOutput({tag, "_rgb"}, 32'(rgb_out), 32'(expRgb));
    checkOutput({tag, "_h"}, 32'(hcount_out), 32'(h));
    checkOutput({tag, "_v"}, 32'(vcount_out), 32'(v));
  endtask

  // Produce a vblnk rising edge with the requested centre on xpos/ypos.
  task automatic vblankRise(input logic [11:0] x, input logic [11:0] y);
    xpos = x;
    ypos = y;
    applyStimulus(12'd0, 12'd768, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    @(posedge clk_in); #1;
    applyStimulus(12'd0, 12'd768, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    applyStimulus(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    @(posedge clk_in); #1;
  endtask

  logic [11:0] histH [0:9];

  initial begin
    xpos = 12'd512;
    ypos = 12'd384;
    rst  = 1'b1;
    applyStimulus(12'd77, 12'd55, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_rgb", 32'(rgb_out), 32'h0);
    checkOutput("reset_h", 32'(hcount_out), 32'h0);
    checkOutput("reset_hs", 32'(hsync_out), 32'h0);
    checkOutput("reset_vs", 32'(vsync_out), 32'h0);
    rst = 1'b0;

    // Centre and radius edges with the puck at (512,384).
    vblankRise(12'd512, 12'd384);
    probePixel("centre", 12'd512, 12'd384, 1'b0, BLUE, RED);
    probePixel("edge256", 12'd528, 12'd384, 1'b0, BLUE, RING);
    probePixel("out289", 12'd529, 12'd384, 1'b0, BLUE, BLUE);
    probePixel("diag242", 12'd523, 12'd395, 1'b0, BLUE, RING);
    probePixel("in225", 12'd527, 12'd384, 1'b0, BLUE, RING);
    probePixel("in196", 12'd526, 12'd384, 1'b0, BLUE, RED);
    probePixel("negdy289", 12'd512, 12'd367, 1'b0, BLUE, BLUE);
    probePixel("negdx256", 12'd496, 12'd384, 1'b0, BLUE, RING);
    probePixel("hblank", 12'd512, 12'd384, 1'b1, BLUE, 12'h000);

    // Mid-frame position request must wait for the next vblnk rise.
    xpos = 12'd100;
    probePixel("midframe_v200", 12'd300, 12'd200, 1'b0, BLUE, BLUE);
    probePixel("stale_centre", 12'd512, 12'd384, 1'b0, BLUE, RED);
    vblankRise(12'd100, 12'd384);
    probePixel("new_centre", 12'd100, 12'd384, 1'b0, BLUE, RED);
    probePixel("old_centre", 12'd512, 12'd384, 1'b0, BLUE, BLUE);

    // Corner puck: negative offsets must not wrap.
    vblankRise(12'd5, 12'd5);
    probePixel("clip_00", 12'd0, 12'd0, 1'b0, BLUE, RED);
    probePixel("clip_55", 12'd5, 12'd5, 1'b0, BLUE, RED);
    probePixel("clip_21_5", 12'd21, 12'd5, 1'b0, BLUE, RING);
    probePixel("clip_0_21", 12'd0, 12'd21, 1'b0, BLUE, BLUE);
    probePixel("clip_far", 12'd1340, 12'd5, 1'b0, BLUE, BLUE);
    probePixel("clip_hblnk", 12'd1335, 12'd5, 1'b1, BLUE, 12'h000);

    // Streaming: timing bus must follow with exactly 2 cycles lag, no bubbles.
    for (int i = 0; i < 10; i++) begin
      histH[i] = 12'(700 + i);
      applyStimulus(histH[i], 12'd300, 1'(i % 2), 1'b0, 1'b0, 1'b0, BLUE);
      @(posedge clk_in); #1;
      if (i >= 1) begin
        checkOutput("stream_h", 32'(hcount_out), 32'(histH[i-1]));
        checkOutput("stream_hs", 32'(hsync_out), 32'((i - 1) % 2));
      end
    end

    // Reset mid-frame returns to the initial centre.
    applyStimulus(12'd512, 12'd300, 1'b1, 1'b1, 1'b0, 1'b0, BLUE);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      checkOutput("midrst_rgb", 32'(rgb_out), 32'h0);
      checkOutput("midrst_v", 32'(vcount_out), 32'h0);
      checkOutput("midrst_vs", 32'(vsync_out), 32'h0);
    end
    rst = 1'b0;
    probePixel("post_rst_centre", 12'd512, 12'd384, 1'b0, BLUE, RED);
    probePixel("post_rst_old", 12'd5, 12'd5, 1'b0, BLUE, BLUE);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
